// File: rtl/trunc_err_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trunc_err_monitor                                            |
// | Description : Measures the error of a truncated multiplier. Each beat      |
// |               gives the operands and the truncated result from the unit   |
// |               under test. The monitor forms the exact product, takes its   |
// |               top RESULT_BIT_WIDTH bits as the ideal value, and collects   |
// |               statistics on |ideal - result_trunc| over num_samples beats. |
// | Ports       : clk, reset (async, active-low)                               |
// |               start, num_samples         - run control                     |
// |               in_valid/in_ready, op_x, op_y, result_trunc - beat stream    |
// |               busy, done                 - run status                      |
// |               sample_count, mismatch_count, err_max, err_sum - statistics  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trunc_err_monitor #(
  parameter int BIT_WIDTH        = 6,
  parameter int RESULT_BIT_WIDTH = 8,
  parameter int COUNT_WIDTH      = 16,
  parameter int SUM_WIDTH        = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [COUNT_WIDTH-1:0]      num_samples,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIT_WIDTH-1:0]        op_x,
  input  logic [BIT_WIDTH-1:0]        op_y,
  input  logic [RESULT_BIT_WIDTH-1:0] result_trunc,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_WIDTH-1:0]      sample_count,
  output logic [COUNT_WIDTH-1:0]      mismatch_count,
  output logic [RESULT_BIT_WIDTH-1:0] err_max,
  output logic [SUM_WIDTH-1:0]        err_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Adder width large enough that sum + err never overflows before saturation.
  localparam int ADD_W = ((SUM_WIDTH > RESULT_BIT_WIDTH) ? SUM_WIDTH : RESULT_BIT_WIDTH) + 1;
  localparam logic [ADD_W-1:0] C_SUM_MAX = {{(ADD_W-SUM_WIDTH){1'b0}}, {SUM_WIDTH{1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = COUNT_WIDTH'(1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        r_drain_cnt;
  logic [COUNT_WIDTH-1:0]      r_beats_left;

  logic                        r_s1_valid;
  logic [BIT_WIDTH-1:0]        r_s1_x;
  logic [BIT_WIDTH-1:0]        r_s1_y;
  logic [RESULT_BIT_WIDTH-1:0] r_s1_res;
  logic                        r_s2_valid;
  logic [RESULT_BIT_WIDTH-1:0] r_s2_err;

  logic                        w_accept;
  logic                        w_start_ok;
  logic [2*BIT_WIDTH-1:0]      w_product;
  logic [RESULT_BIT_WIDTH-1:0] w_ideal;
  logic [RESULT_BIT_WIDTH-1:0] w_err;
  logic [ADD_W-1:0]            w_sum_ext;

  assign w_accept   = in_valid && (r_state == RUN);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          w_state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (r_beats_left == C_CNT_ONE)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Two DRAIN cycles let the last beat reach the statistics stage, so
        // DONE entry lines up with its update.
        if (r_drain_cnt) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain_cnt  <= 1'b0;
      r_beats_left <= '0;
    end else begin
      r_drain_cnt <= (r_state == DRAIN);
      if (w_start_ok) begin
        r_beats_left <= num_samples;
      end else if (w_accept) begin
        r_beats_left <= r_beats_left - C_CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------- pipeline
  assign w_product = {{BIT_WIDTH{1'b0}}, r_s1_x} * {{BIT_WIDTH{1'b0}}, r_s1_y};
  assign w_ideal   = w_product[2*BIT_WIDTH-1 -: RESULT_BIT_WIDTH];
  assign w_err     = (w_ideal >= r_s1_res) ? (w_ideal - r_s1_res) : (r_s1_res - w_ideal);

  // A start clears the valid flags so nothing from a previous run leaks in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_res   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= '0;
    end else begin
      r_s1_valid <= w_accept && !w_start_ok;
      r_s2_valid <= r_s1_valid && !w_start_ok;
      if (w_accept) begin
        r_s1_x   <= op_x;
        r_s1_y   <= op_y;
        r_s1_res <= result_trunc;
      end
      r_s2_err <= w_err;
    end
  end

  // ---------------------------------------------------------------- statistics
  assign w_sum_ext = {{(ADD_W-SUM_WIDTH){1'b0}}, err_sum}
                   + {{(ADD_W-RESULT_BIT_WIDTH){1'b0}}, r_s2_err};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_count   <= '0;
      mismatch_count <= '0;
      err_max        <= '0;
      err_sum        <= '0;
    end else if (w_start_ok) begin
      sample_count   <= '0;
      mismatch_count <= '0;
      err_max        <= '0;
      err_sum        <= '0;
    end else if (r_s2_valid) begin
      if (sample_count != C_CNT_MAX) begin
        sample_count <= sample_count + C_CNT_ONE;
      end
      if ((r_s2_err != '0) && (mismatch_count != C_CNT_MAX)) begin
        mismatch_count <= mismatch_count + C_CNT_ONE;
      end
      if (r_s2_err > err_max) begin
        err_max <= r_s2_err;
      end
      err_sum <= (w_sum_ext > C_SUM_MAX) ? {SUM_WIDTH{1'b1}} : w_sum_ext[SUM_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trunc_err_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trunc_err_monitor                                         |
// | Description : Self-checking bench for trunc_err_monitor. Drives one shared |
// |               stimulus into a default instance and a SUM_WIDTH=4 instance. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_trunc_err_monitor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [5:0]  op_x;
  logic [5:0]  op_y;
  logic [7:0]  result_trunc;

  logic        in_ready, busy, done;
  logic [15:0] sample_count, mismatch_count;
  logic [7:0]  err_max;
  logic [23:0] err_sum;

  logic        b_in_ready, b_busy, b_done;
  logic [15:0] b_sample_count, b_mismatch_count;
  logic [7:0]  b_err_max;
  logic [3:0]  b_err_sum;

  int checks   = 0;
  int failures = 0;

  trunc_err_monitor #(
    .BIT_WIDTH(6), .RESULT_BIT_WIDTH(8), .COUNT_WIDTH(16), .SUM_WIDTH(24)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_x(op_x), .op_y(op_y),
    .result_trunc(result_trunc), .busy(busy), .done(done),
    .sample_count(sample_count), .mismatch_count(mismatch_count),
    .err_max(err_max), .err_sum(err_sum)
  );

  trunc_err_monitor #(
    .BIT_WIDTH(6), .RESULT_BIT_WIDTH(8), .COUNT_WIDTH(16), .SUM_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(b_in_ready), .op_x(op_x), .op_y(op_y),
    .result_trunc(result_trunc), .busy(b_busy), .done(b_done),
    .sample_count(b_sample_count), .mismatch_count(b_mismatch_count),
    .err_max(b_err_max), .err_sum(b_err_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [7:0] r;
    int         smp;
    int         sum;
    int         mx;
    int         mis;
    int         sum_b;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [5:0] x, input logic [5:0] y, input logic [7:0] r);
    in_valid     = 1'b1;
    op_x         = x;
    op_y         = y;
    result_trunc = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int smp, input int sum, input int mx, input int mis);
    chk({tag, "_sample_count"}, 32'(sample_count), smp);
    chk({tag, "_err_sum"}, 32'(err_sum), sum);
    chk({tag, "_err_max"}, 32'(err_max), mx);
    chk({tag, "_mismatch_count"}, 32'(mismatch_count), mis);
  endtask

  initial begin
    vecs[0] = '{6'd63, 6'd63, 8'd248, 1,  0,  0, 0,  0};
    vecs[1] = '{6'd63, 6'd63, 8'd245, 2,  3,  3, 1,  3};
    vecs[2] = '{6'd5,  6'd3,  8'd2,   3,  5,  3, 2,  5};
    vecs[3] = '{6'd0,  6'd0,  8'd7,   4, 12,  7, 3, 12};
    vecs[4] = '{6'd63, 6'd63, 8'd255, 5, 19,  7, 4, 15};
    vecs[5] = '{6'd32, 6'd32, 8'd16,  6, 67, 48, 5, 15};
    vecs[6] = '{6'd10, 6'd20, 8'd12,  7, 67, 48, 5, 15};
    vecs[7] = '{6'd63, 6'd1,  8'd0,   8, 70, 48, 6, 15};

    reset = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    op_x = '0; op_y = '0; result_trunc = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk_stats("rst", 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Table: one beat at a time, statistics checked one edge and two edges later.
    do_start(16'd8);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_in_ready", 32'(in_ready), 1);
      beat(vecs[i].x, vecs[i].y, vecs[i].r);
      tick();
      chk("tbl_latency_sample_count", 32'(sample_count), i);
      tick();
      chk_stats("tbl", vecs[i].smp, vecs[i].sum, vecs[i].mx, vecs[i].mis);
      chk("tbl_b_err_sum", 32'(b_err_sum), vecs[i].sum_b);
      chk("tbl_done", 32'(done), (i == 7) ? 1 : 0);
    end

    // Back-to-back beats.
    do_start(16'd3);
    chk("b2b_stats_cleared", 32'(sample_count), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_x = vecs[i].x; op_y = vecs[i].y; result_trunc = vecs[i].r;
      chk("b2b_in_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_drain_busy", 32'(busy), 1);
    tick();
    chk("b2b_done_early", 32'(done), 0);
    tick();
    chk("b2b_done", 32'(done), 1);
    chk_stats("b2b", 3, 5, 3, 2);

    // Random gaps between beats.
    do_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      automatic int gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) begin
        chk("gap_in_ready", 32'(in_ready), 1);
        tick();
      end
      beat(vecs[i].x, vecs[i].y, vecs[i].r);
    end
    tick(); tick();
    chk("gap_done", 32'(done), 1);
    chk_stats("gap", 3, 5, 3, 2);

    // Saturation of err_sum in the narrow instance.
    do_start(16'd6);
    in_valid = 1'b1; op_x = 6'd63; op_y = 6'd63; result_trunc = 8'd245;
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sat_b_err_sum", 32'(b_err_sum), 15);
    chk("sat_b_err_max", 32'(b_err_max), 3);
    chk("sat_b_mismatch_count", 32'(b_mismatch_count), 6);
    chk("sat_b_sample_count", 32'(b_sample_count), 6);
    chk("sat_b_done", 32'(b_done), 1);
    chk("sat_b_busy", 32'(b_busy), 0);
    chk("sat_b_in_ready", 32'(b_in_ready), 0);
    chk("sat_a_err_sum", 32'(err_sum), 18);

    // Zero-length run.
    do_start(16'd0);
    chk("zero_done", 32'(done), 1);
    chk("zero_in_ready", 32'(in_ready), 0);
    chk("zero_busy", 32'(busy), 0);
    chk_stats("zero", 0, 0, 0, 0);
    tick();
    chk("zero_in_ready_hold", 32'(in_ready), 0);

    // Reset mid-run.
    do_start(16'd5);
    beat(6'd63, 6'd63, 8'd245);
    beat(6'd5, 6'd3, 8'd2);
    tick(); tick();
    chk("midrst_pre_sample_count", 32'(sample_count), 2);
    #2 reset = 1'b0;
    #1;
    chk_stats("midrst_async", 0, 0, 0, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_idle_busy", 32'(busy), 0);
    chk("midrst_idle_done", 32'(done), 0);
    chk("midrst_idle_in_ready", 32'(in_ready), 0);
    do_start(16'd1);
    beat(6'd63, 6'd63, 8'd248);
    tick(); tick();
    chk("midrst_new_done", 32'(done), 1);
    chk_stats("midrst_new", 1, 0, 0, 0);

    // Start ignored in RUN and DRAIN; honoured in DONE.
    do_start(16'd2);
    do_start(16'd9);
    chk("ign_run_busy", 32'(busy), 1);
    chk("ign_run_in_ready", 32'(in_ready), 1);
    beat(6'd63, 6'd63, 8'd245);
    beat(6'd5, 6'd3, 8'd2);
    do_start(16'd9);
    chk("ign_drain_in_ready", 32'(in_ready), 0);
    tick();
    chk("ign_done", 32'(done), 1);
    chk_stats("ign", 2, 5, 3, 2);
    do_start(16'd1);
    chk_stats("restart", 0, 0, 0, 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
    beat(6'd5, 6'd3, 8'd2);
    tick(); tick();
    chk_stats("restart_end", 1, 2, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
